// File: rtl/serdes_tx_arbiter.sv
// serdes_tx_arbiter: round-robin burst scheduler of two FWFT FIFOs onto one 64-bit SERDES tx word stream.
// Define SERDES_TX_ARB_TRAILER_EN to append a trailer word carrying channel, per-channel sequence and word count.
module serdes_tx_arbiter #(
  parameter int MAX_BURST  = 256,
  parameter int CH0_THRESH = 512,
  parameter int LVL_W      = 10
) (
  input  logic             I_sys_clk,
  input  logic             I_rst_n,
  input  logic             I_enable,
  input  logic [63:0]      I_ch0_dat,
  input  logic             I_ch0_empty,
  input  logic [LVL_W-1:0] I_ch0_level,
  output logic             O_ch0_rd_en,
  input  logic [63:0]      I_ch1_dat,
  input  logic             I_ch1_empty,
  output logic             O_ch1_rd_en,
  output logic [63:0]      O_tx_dat,
  output logic             O_tx_is_k,
  output logic             O_busy,
  output logic             O_cur_chan
);
  localparam logic [2:0] S_ARB = 3'd0;
  localparam logic [2:0] S_H0  = 3'd1;
  localparam logic [2:0] S_H1  = 3'd2;
  localparam logic [2:0] S_H2  = 3'd3;
  localparam logic [2:0] S_PAY = 3'd4;
  localparam logic [63:0] IDLE  = 64'hc5bc_c5bc_c5bc_c5bc;
  localparam logic [63:0] HDR0  = 64'h1c1c_1c1c_1c1c_1c1c;
  localparam logic [63:0] HDR1  = 64'h3c3c_3c3c_3c3c_3c3c;
  localparam logic [63:0] HDR2A = 64'h5c5c_5c5c_5c5c_5c5c;
  localparam logic [63:0] HDR2B = 64'h7c7c_7c7c_7c7c_7c7c;
  localparam logic [9:0] LAST = 10'(MAX_BURST - 1);
  localparam logic [LVL_W-1:0] THR = LVL_W'(CH0_THRESH);
`ifdef SERDES_TX_ARB_TRAILER_EN
  localparam logic [2:0] S_TRL = 3'd5;
  localparam logic [2:0] S_END = S_TRL;
`else
  localparam logic [2:0] S_END = S_ARB;
`endif
  logic [2:0]  r_state, w_next;
  logic [9:0]  r_cnt;
  logic        r_rr_last, w_elig0, w_elig1, w_grant, w_cur_empty, w_pay;
  logic [63:0] w_cur_dat, w_tx_dat, w_tail;
  assign w_elig0     = I_enable & ~I_ch0_empty & (I_ch0_level >= THR);
  assign w_elig1     = I_enable & ~I_ch1_empty;
  assign w_grant     = (w_elig0 & w_elig1) ? ~r_rr_last : w_elig1;
  assign w_cur_empty = O_cur_chan ? I_ch1_empty : I_ch0_empty;
  assign w_cur_dat   = O_cur_chan ? I_ch1_dat : I_ch0_dat;
  assign w_pay       = (r_state == S_PAY) & ~w_cur_empty;
  assign O_ch0_rd_en = w_pay & ~O_cur_chan;
  assign O_ch1_rd_en = w_pay & O_cur_chan;
  always_comb begin
    w_next = S_ARB;
    case (r_state)
      S_ARB:   w_next = (w_elig0 | w_elig1) ? S_H0 : S_ARB;
      S_H0:    w_next = S_H1;
      S_H1:    w_next = S_H2;
      S_H2:    w_next = S_PAY;
      S_PAY:   w_next = (w_cur_empty || r_cnt == LAST) ? S_END : S_PAY;
      default: w_next = S_ARB;
    endcase
  end
`ifdef SERDES_TX_ARB_TRAILER_EN
  logic [7:0] r_seq0, r_seq1;
  assign w_tail = (r_state == S_TRL) ?
    {16'hfdfd, 7'd0, O_cur_chan, O_cur_chan ? r_seq1 : r_seq0, 16'd0, 6'd0, r_cnt} : IDLE;
  always_ff @(posedge I_sys_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_seq0 <= 8'd0;
      r_seq1 <= 8'd0;
    end else if (r_state == S_TRL) begin
      r_seq0 <= O_cur_chan ? r_seq0 : r_seq0 + 8'd1;
      r_seq1 <= O_cur_chan ? r_seq1 + 8'd1 : r_seq1;
    end
`else
  assign w_tail = IDLE;
`endif
  // An empty granted FIFO in PAY falls through to w_tail, which is the idle word there
  assign w_tx_dat = (r_state == S_H0) ? HDR0 :
                    (r_state == S_H1) ? HDR1 :
                    (r_state == S_H2) ? (O_cur_chan ? HDR2B : HDR2A) :
                    w_pay ? w_cur_dat : w_tail;
  always_ff @(posedge I_sys_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_state    <= S_ARB;
      r_cnt      <= 10'd0;
      r_rr_last  <= 1'b1;
      O_tx_dat   <= 64'h0;
      O_tx_is_k  <= 1'b0;
      O_busy     <= 1'b0;
      O_cur_chan <= 1'b0;
    end else begin
      r_state   <= w_next;
      O_busy    <= w_next != S_ARB;
      O_tx_dat  <= w_tx_dat;
      O_tx_is_k <= w_pay;
      r_cnt     <= (w_next == S_H0) ? 10'd0 : r_cnt + {9'd0, w_pay};
      if (w_next == S_H0) begin
        r_rr_last  <= w_grant;
        O_cur_chan <= w_grant;
      end
    end
endmodule

// File: tb/tb_serdes_tx_arbiter.sv
// tb_serdes_tx_arbiter: randomized FIFO contents drained through the arbiter, checked against a queue-level burst model.
module tb_serdes_tx_arbiter;
  localparam logic [63:0] IDLE = 64'hc5bc_c5bc_c5bc_c5bc;
  localparam logic [63:0] H0W  = 64'h1c1c_1c1c_1c1c_1c1c;
  localparam logic [63:0] H1W  = 64'h3c3c_3c3c_3c3c_3c3c;
  localparam logic [63:0] H2A  = 64'h5c5c_5c5c_5c5c_5c5c;
  localparam logic [63:0] H2B  = 64'h7c7c_7c7c_7c7c_7c7c;
  logic        I_sys_clk = 0, I_rst_n = 0, I_enable = 0;
  logic [63:0] I_ch0_dat = '0, I_ch1_dat = '0;
  logic        I_ch0_empty = 1, I_ch1_empty = 1;
  logic [9:0]  I_ch0_level = '0;
  logic        O_ch0_rd_en, O_ch1_rd_en, O_tx_is_k, O_busy, O_cur_chan;
  logic [63:0] O_tx_dat;
  serdes_tx_arbiter dut (
    .I_sys_clk(I_sys_clk), .I_rst_n(I_rst_n), .I_enable(I_enable),
    .I_ch0_dat(I_ch0_dat), .I_ch0_empty(I_ch0_empty), .I_ch0_level(I_ch0_level), .O_ch0_rd_en(O_ch0_rd_en),
    .I_ch1_dat(I_ch1_dat), .I_ch1_empty(I_ch1_empty), .O_ch1_rd_en(O_ch1_rd_en),
    .O_tx_dat(O_tx_dat), .O_tx_is_k(O_tx_is_k), .O_busy(O_busy), .O_cur_chan(O_cur_chan)
  );
  always #5 I_sys_clk = ~I_sys_clk;
  logic [63:0] q0[$], q1[$];
  logic        pop0 = 0, pop1 = 0, mon_on = 0, m_rr = 1;
  logic [64:0] raw[$], filt[$], exp_w[$];
  logic        exp_c[$], obs_c[$];
  int          rd0, rd1, viol, kcnt, exp_rd0, exp_rd1;
  int          total = 0, bad = 0;
`ifdef SERDES_TX_ARB_TRAILER_EN
  logic [7:0]  m_seq[2];
`endif
  function automatic logic [63:0] gen(input logic c);
    return {c ? 8'hb6 : 8'ha5, 24'($urandom), 32'($urandom)};
  endfunction
  // FWFT FIFO models: pops seen on the falling edge take effect just after the next rising edge
  always @(posedge I_sys_clk) begin
    #1;
    if (pop0 && I_rst_n && q0.size() > 0) void'(q0.pop_front());
    if (pop1 && I_rst_n && q1.size() > 0) void'(q1.pop_front());
    I_ch0_empty = q0.size() == 0;
    I_ch1_empty = q1.size() == 0;
    I_ch0_dat   = (q0.size() > 0) ? q0[0] : 64'h0;
    I_ch1_dat   = (q1.size() > 0) ? q1[0] : 64'h0;
    I_ch0_level = (q0.size() > 1023) ? 10'd1023 : 10'(q0.size());
  end
  always @(negedge I_sys_clk) begin
    pop0 = O_ch0_rd_en;
    pop1 = O_ch1_rd_en;
    if (mon_on) begin
      raw.push_back({O_tx_is_k, O_tx_dat});
      if (O_tx_dat !== IDLE) filt.push_back({O_tx_is_k, O_tx_dat});
      if (O_tx_dat === H0W) obs_c.push_back(O_cur_chan);
      rd0 += int'(O_ch0_rd_en);
      rd1 += int'(O_ch1_rd_en);
      kcnt += int'(O_tx_is_k);
      if ((O_ch0_rd_en && O_cur_chan) || (O_ch1_rd_en && !O_cur_chan)) viol++;
    end
  end
  task automatic clear_mon();
    raw.delete(); filt.delete(); obs_c.delete();
    rd0 = 0; rd1 = 0; viol = 0; kcnt = 0; mon_on = 1;
  endtask
  task automatic do_reset();
    I_rst_n = 0;
    m_rr = 1;
`ifdef SERDES_TX_ARB_TRAILER_EN
    m_seq = '{8'd0, 8'd0};
`endif
    repeat (2) @(negedge I_sys_clk);
    I_rst_n = 1;
    @(negedge I_sys_clk);
  endtask
  task automatic fresh();
    I_enable = 0;
    mon_on = 0;
    q0.delete(); q1.delete();
    do_reset();
  endtask
  // Expected non-idle word stream from queue contents and the grant rules alone
  task automatic build_exp(input int maxb);
    logic [63:0] m0[$], m1[$];
    logic c;
    int n, nb;
    m0 = q0; m1 = q1; nb = 0;
    exp_w.delete(); exp_c.delete(); exp_rd0 = 0; exp_rd1 = 0;
    while (nb < maxb && (m0.size() >= 512 || m1.size() > 0)) begin
      c = (m0.size() >= 512 && m1.size() > 0) ? !m_rr : (m1.size() > 0);
      m_rr = c; nb++;
      exp_c.push_back(c);
      exp_w.push_back({1'b0, H0W});
      exp_w.push_back({1'b0, H1W});
      exp_w.push_back({1'b0, c ? H2B : H2A});
      n = 0;
      while (n < 256 && (c ? m1.size() : m0.size()) > 0) begin
        if (c) exp_w.push_back({1'b1, m1.pop_front()});
        else exp_w.push_back({1'b1, m0.pop_front()});
        n++;
      end
      if (c) exp_rd1 += n; else exp_rd0 += n;
`ifdef SERDES_TX_ARB_TRAILER_EN
      exp_w.push_back({1'b0, 16'hfdfd, 7'd0, c, m_seq[c], 16'd0, 16'(n)});
      m_seq[c]++;
`endif
    end
  endtask
  task automatic go(input int n0, input int n1, input int maxb);
    I_enable = 0;
    repeat (n0) q0.push_back(gen(1'b0));
    repeat (n1) q1.push_back(gen(1'b1));
    @(negedge I_sys_clk);
    I_enable = 1;
    build_exp(maxb);
    clear_mon();
  endtask
  task automatic run_quiet();
    int quiet = 0, n = 0;
    while (quiet < 8 && n < 6000) begin
      @(negedge I_sys_clk);
      n++;
      quiet = O_busy ? 0 : quiet + 1;
    end
    total++;
    if (n >= 6000) begin bad++; $display("FAIL quiet_timeout busy=%b required=0", O_busy); end
  endtask
  task automatic test_reset();
    q1.push_back(gen(1'b1));
    I_enable = 1;
    I_rst_n = 0;
    repeat (3) @(negedge I_sys_clk);
    total += 3;
    if (O_tx_dat !== 64'h0) begin bad++; $display("FAIL rst_dat got=%h exp=0", O_tx_dat); end
    if ({O_tx_is_k, O_busy, O_cur_chan} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {O_tx_is_k, O_busy, O_cur_chan}); end
    if ({O_ch0_rd_en, O_ch1_rd_en} !== 2'b00) begin bad++; $display("FAIL rst_rden got=%b exp=00", {O_ch0_rd_en, O_ch1_rd_en}); end
  endtask
  task automatic test_idle();
    fresh();
    I_enable = 1;
    repeat (8) begin
      @(negedge I_sys_clk);
      total++;
      if ({O_tx_is_k, O_tx_dat} !== {1'b0, IDLE} || O_ch0_rd_en || O_ch1_rd_en)
        begin bad++; $display("FAIL idle got=%b_%h rd=%b%b exp=0_%h rd=00", O_tx_is_k, O_tx_dat, O_ch0_rd_en, O_ch1_rd_en, IDLE); end
    end
  endtask
  task automatic test_thresh();
    fresh();
    go(511, 0, 100);
    repeat (20) @(negedge I_sys_clk);
    total += 2;
    if (filt.size() != 0) begin bad++; $display("FAIL thr511_words got=%0d exp=0", filt.size()); end
    if (rd0 != 0) begin bad++; $display("FAIL thr511_rd got=%0d exp=0", rd0); end
    q0.push_back(gen(1'b0));
    build_exp(100);
    clear_mon();
    run_quiet();
    total += 3;
    if (filt.size() != exp_w.size()) begin bad++; $display("FAIL thr_len got=%0d exp=%0d", filt.size(), exp_w.size()); end
    if (rd0 != 256) begin bad++; $display("FAIL thr_rd0 got=%0d exp=256", rd0); end
    if (viol != 0) begin bad++; $display("FAIL thr_rd_chan got=%0d exp=0", viol); end
    for (int i = 0; i < exp_w.size() && i < filt.size(); i++) begin
      total++;
      if (filt[i] !== exp_w[i]) begin bad++; $display("FAIL thr_word[%0d] got=%h exp=%h", i, filt[i], exp_w[i]); end
    end
  endtask
  task automatic test_ch1_short();
    int last = -1;
    fresh();
    go(0, 5, 100);
    run_quiet();
    total += 3;
    if (filt.size() != exp_w.size()) begin bad++; $display("FAIL short_len got=%0d exp=%0d", filt.size(), exp_w.size()); end
    if (rd1 != 5 || rd0 != 0) begin bad++; $display("FAIL short_rd got=%0d/%0d exp=0/5", rd0, rd1); end
    for (int i = 0; i < raw.size(); i++) if (raw[i][64]) last = i;
    if (last < 0 || last + 1 >= raw.size() || raw[last+1] !== {1'b0, IDLE})
      begin bad++; $display("FAIL short_idle_after idx=%0d exp=idle after last payload", last); end
    for (int i = 0; i < exp_w.size() && i < filt.size(); i++) begin
      total++;
      if (filt[i] !== exp_w[i]) begin bad++; $display("FAIL short_word[%0d] got=%h exp=%h", i, filt[i], exp_w[i]); end
    end
  endtask
  task automatic test_tie();
    fresh();
    go(900, 400, 100);
    run_quiet();
    total += 3;
    if (filt.size() != exp_w.size()) begin bad++; $display("FAIL tie_len got=%0d exp=%0d", filt.size(), exp_w.size()); end
    if (obs_c.size() != 4 || exp_c.size() != 4) begin bad++; $display("FAIL tie_grants got=%0d exp=4", obs_c.size()); end
    if (rd0 != exp_rd0 || rd1 != exp_rd1) begin bad++; $display("FAIL tie_rd got=%0d/%0d exp=%0d/%0d", rd0, rd1, exp_rd0, exp_rd1); end
    for (int i = 0; i < exp_c.size() && i < obs_c.size(); i++) begin
      total++;
      if (obs_c[i] !== exp_c[i] || obs_c[i] !== 1'(i % 2)) begin bad++; $display("FAIL tie_chan[%0d] got=%b exp=%b", i, obs_c[i], exp_c[i]); end
    end
    for (int i = 0; i < exp_w.size() && i < filt.size(); i++) begin
      total++;
      if (filt[i] !== exp_w[i]) begin bad++; $display("FAIL tie_word[%0d] got=%h exp=%h", i, filt[i], exp_w[i]); end
    end
  endtask
  task automatic test_enable_drop();
    int n = 0;
    fresh();
    go(600, 3, 1);
    while (kcnt < 10 && n < 50) begin @(negedge I_sys_clk); n++; end
    I_enable = 0;
    run_quiet();
    total += 3;
    if (filt.size() != exp_w.size()) begin bad++; $display("FAIL endrop_len got=%0d exp=%0d", filt.size(), exp_w.size()); end
    if (rd0 != 256 || rd1 != 0) begin bad++; $display("FAIL endrop_rd got=%0d/%0d exp=256/0", rd0, rd1); end
    if (obs_c.size() != 1) begin bad++; $display("FAIL endrop_grants got=%0d exp=1", obs_c.size()); end
    for (int i = 0; i < exp_w.size() && i < filt.size(); i++) begin
      total++;
      if (filt[i] !== exp_w[i]) begin bad++; $display("FAIL endrop_word[%0d] got=%h exp=%h", i, filt[i], exp_w[i]); end
    end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    fresh();
    go(0, 20, 100);
    while (kcnt < 5 && n < 50) begin @(negedge I_sys_clk); n++; end
    I_rst_n = 0;
    m_rr = 1;
`ifdef SERDES_TX_ARB_TRAILER_EN
    m_seq = '{8'd0, 8'd0};
`endif
    #1;
    total++;
    if ({O_ch0_rd_en, O_ch1_rd_en} !== 2'b00) begin bad++; $display("FAIL rstmid_rden got=%b exp=00", {O_ch0_rd_en, O_ch1_rd_en}); end
    @(negedge I_sys_clk);
    total += 2;
    if ({O_tx_is_k, O_tx_dat} !== 65'h0) begin bad++; $display("FAIL rstmid_dat got=%b_%h exp=0_0", O_tx_is_k, O_tx_dat); end
    if ({O_busy, O_cur_chan, O_ch0_rd_en, O_ch1_rd_en} !== 4'b0) begin bad++; $display("FAIL rstmid_flags got=%b exp=0000", {O_busy, O_cur_chan, O_ch0_rd_en, O_ch1_rd_en}); end
    mon_on = 0;
    I_rst_n = 1;
    @(negedge I_sys_clk);
    build_exp(100);
    clear_mon();
    run_quiet();
    total += 2;
    if (filt.size() != exp_w.size()) begin bad++; $display("FAIL rstmid_len got=%0d exp=%0d", filt.size(), exp_w.size()); end
    if (rd1 != exp_rd1) begin bad++; $display("FAIL rstmid_rd got=%0d exp=%0d", rd1, exp_rd1); end
    for (int i = 0; i < exp_w.size() && i < filt.size(); i++) begin
      total++;
      if (filt[i] !== exp_w[i]) begin bad++; $display("FAIL rstmid_word[%0d] got=%h exp=%h", i, filt[i], exp_w[i]); end
    end
  endtask
  task automatic test_random();
    fresh();
    for (int it = 0; it < 3; it++) begin
      go($urandom_range(0, 1000 - q0.size()), $urandom_range(0, 300), 100);
      run_quiet();
      total += 4;
      if (filt.size() != exp_w.size()) begin bad++; $display("FAIL rnd%0d_len got=%0d exp=%0d", it, filt.size(), exp_w.size()); end
      if (rd0 != exp_rd0 || rd1 != exp_rd1) begin bad++; $display("FAIL rnd%0d_rd got=%0d/%0d exp=%0d/%0d", it, rd0, rd1, exp_rd0, exp_rd1); end
      if (obs_c != exp_c) begin bad++; $display("FAIL rnd%0d_chans got=%0d exp=%0d grants", it, obs_c.size(), exp_c.size()); end
      if (viol != 0) begin bad++; $display("FAIL rnd%0d_rd_chan got=%0d exp=0", it, viol); end
      for (int i = 0; i < exp_w.size() && i < filt.size(); i++) begin
        total++;
        if (filt[i] !== exp_w[i]) begin bad++; $display("FAIL rnd%0d_word[%0d] got=%h exp=%h", it, i, filt[i], exp_w[i]); end
      end
    end
  endtask
`ifdef SERDES_TX_ARB_TRAILER_EN
  task automatic test_trailer();
    fresh();
    go(0, 5, 100);
    run_quiet();
    total += 2;
    if (filt.size() != 9) begin bad++; $display("FAIL trl1_len got=%0d exp=9", filt.size()); end
    if (filt.size() < 9 || filt[8] !== {1'b0, 64'hfdfd_0100_0000_0005})
      begin bad++; $display("FAIL trl1_word got=%h exp=0_fdfd010000000005", filt.size() > 8 ? filt[8] : 65'h0); end
    go(0, 5, 100);
    run_quiet();
    total += 2;
    if (filt.size() != 9) begin bad++; $display("FAIL trl2_len got=%0d exp=9", filt.size()); end
    if (filt.size() < 9 || filt[8] !== {1'b0, 64'hfdfd_0101_0000_0005})
      begin bad++; $display("FAIL trl2_word got=%h exp=0_fdfd010100000005", filt.size() > 8 ? filt[8] : 65'h0); end
  endtask
`endif
  initial begin
    test_reset();
    test_idle();
    test_thresh();
    test_ch1_short();
    test_tie();
    test_enable_drop();
    test_reset_mid();
    test_random();
`ifdef SERDES_TX_ARB_TRAILER_EN
    test_trailer();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serdes_tx_arbiter.md
Name: serdes_tx_arbiter

Overview:
- Schedules one 64-bit SERDES tx word stream, shared between two upstream first-word-fall-through (FWFT) FIFOs.
  - CH0: bulk I/Q result words.
  - CH1: target/energy records.
- Each grant is one burst. A 3-word channel header goes first, then up to MAX_BURST payload words.
- Sits between the tx FIFOs' read side and the 4-lane SERDES splitter, which maps word bits [16k+15:16k] to lane k+1.
- Outputs idle words whenever no burst is active.

Parameters:
- MAX_BURST, 256, maximum payload words per burst (2..1023).
- CH0_THRESH, 512, minimum CH0 FIFO fill before CH0 may start a burst.
- LVL_W, 10, width of the CH0 fill-level input.

Ports:
- I_sys_clk  in  1  clock (all logic in this domain)
- I_rst_n  in  1  reset, asynchronous, active-low
- I_enable  in  1  1 = new bursts may be granted
- I_ch0_dat  in  64  CH0 FWFT head word
- I_ch0_empty  in  1  CH0 FIFO empty
- I_ch0_level  in  LVL_W  CH0 FIFO fill count
- O_ch0_rd_en  out  1  CH0 pop (combinational)
- I_ch1_dat  in  64  CH1 FWFT head word
- I_ch1_empty  in  1  CH1 FIFO empty
- O_ch1_rd_en  out  1  CH1 pop (combinational)
- O_tx_dat  out  64  tx word (registered)
- O_tx_is_k  out  1  1 = payload word, 0 = header/idle/trailer (registered)
- O_busy  out  1  1 while a burst is in progress (state != ARB)
- O_cur_chan  out  1  channel of current/last grant

Behaviour:
- Reset values (asynchronous): state=ARB, O_tx_dat=64'h0, O_tx_is_k=0, O_busy=0, O_cur_chan=0, rr_last=1, burst count=0. Both rd_en are 0 in ARB.
- States: ARB -> H0 -> H1 -> H2 -> PAY -> [TRL] -> ARB. Each state is 1 cycle except PAY.
- ARB:
  - Output word: idle 64'hc5bc_c5bc_c5bc_c5bc, is_k=0.
  - elig0 = I_enable & ~I_ch0_empty & (I_ch0_level >= CH0_THRESH).
  - elig1 = I_enable & ~I_ch1_empty.
  - Exactly one eligible: grant it.
  - Both eligible: grant ~rr_last. After reset CH0 wins the first tie.
  - On grant: rr_last <= granted channel, O_cur_chan <= granted channel, go to H0.
- Headers (output registered in the header state's cycle):
  - CH0: H0 64'h1c1c.., H1 64'h3c3c.., H2 64'h5c5c...
  - CH1: H0 64'h1c1c.., H1 64'h3c3c.., H2 64'h7c7c...
  - is_k=0 for all header words.
- PAY, each cycle:
  - Granted FIFO not empty:
    - rd_en=1 that cycle.
    - O_tx_dat <= I_chX_dat, is_k <= 1.
    - cnt++.
    - If cnt reaches MAX_BURST: leave PAY.
  - Granted FIFO empty:
    - rd_en=0.
    - Output idle word, is_k=0.
    - Leave PAY. Burst is short, cnt is the number of words sent.
  - Only the granted channel's rd_en is ever asserted. The other channel's rd_en stays 0.
  - Latency: FWFT head word to O_tx_dat is 1 clock.
- Leaving PAY: go to TRL if the optional feature is compiled in, else ARB. cnt clears on entry to H0.
- I_enable deasserted mid-burst: the current burst completes normally and no new grant follows. I_enable only gates ARB.
- I_ch0_level may fall below CH0_THRESH mid-burst; this has no effect once granted.
- Reset asserted mid-burst: immediate return to reset values. No rd_en is asserted while reset is active. The partial burst is lost and is not resumed.
- O_busy = (state != ARB), registered together with state.

Optional Feature:
- Macro: SERDES_TX_ARB_TRAILER_EN.
- Defined:
  - After PAY, one TRL cycle emits {16'hfdfd, 7'd0, chan, 8'd seq, 16'd0, 16'd cnt}, is_k=0.
  - seq is a per-channel 8-bit burst counter. It increments after each trailer, wraps 255 -> 0, and resets to 0.
- Undefined:
  - No TRL state and no seq counters.
  - PAY goes directly to ARB.

Test Plan:
- Reset then idle: I_enable=1, both FIFOs empty -> O_tx_dat=64'hc5bc_c5bc_c5bc_c5bc and is_k=0 every cycle; rd_en never asserted.
- CH0 threshold: level=511 with data present -> no grant. Level=512 -> sequence 1c.., 3c.., 5c.., then 256 payload words (is_k=1) equal to FIFO contents in order, with exactly 256 O_ch0_rd_en pulses, then idle.
- CH1 short burst: 5 records queued -> 1c.., 3c.., 7c.., 5 payload words, 1 idle, back to ARB. O_ch1_rd_en high for exactly 5 cycles.
- Tie round-robin: both eligible continuously -> grants alternate CH0, CH1, CH0; O_cur_chan toggles per burst.
- Disruption: I_enable dropped at payload word 10 -> burst still runs to 256 words with no further grant. Separately, I_rst_n pulsed low mid-PAY -> outputs are 0/idle on the next clock and rd_en stays 0.
- With SERDES_TX_ARB_TRAILER_EN: two CH1 bursts of 5 words -> trailers 64'hfdfd_0100_0000_0005 and 64'hfdfd_0101_0000_0005.
